// File: rtl/sdram_arbiter_nport_if.sv
// Bus bundle between the bus masters, the arbiter and the SDRAM controller.
// The slave modport is the arbiter's view; master is the surrounding system.
interface sdram_arbiter_nport_if #(
  parameter int NUM_MASTERS = 5,
  parameter int ADDR_W      = 26,
  parameter int DATA_W      = 32,
  parameter int ID_W        = 4
);
  logic [NUM_MASTERS-1:0]          m_request;
  logic [NUM_MASTERS-1:0]          m_write;
  logic [NUM_MASTERS-1:0]          m_burst;
  logic [NUM_MASTERS*ADDR_W-1:0]   m_address;
  logic [NUM_MASTERS*DATA_W-1:0]   m_wdata;
  logic [NUM_MASTERS*DATA_W/8-1:0] m_byte_en;
  logic [NUM_MASTERS-1:0]          m_ack;
  logic [NUM_MASTERS-1:0]          m_valid;
  logic [NUM_MASTERS-1:0]          m_complete;
  logic [DATA_W-1:0]               m_rdata;

  logic                            sdram_request;
  logic                            sdram_write;
  logic [ID_W-1:0]                 sdram_master;
  logic [ADDR_W-1:0]               sdram_address;
  logic [DATA_W-1:0]               sdram_wdata;
  logic [DATA_W/8-1:0]             sdram_byte_en;
  logic                            sdram_burst;
  logic                            sdram_ready;
  logic [DATA_W-1:0]               sdram_rdata;
  logic [ID_W-1:0]                 sdram_valid;
  logic [ID_W-1:0]                 sdram_complete;

  modport slave (
    input  m_request, m_write, m_burst, m_address, m_wdata, m_byte_en,
    output m_ack, m_valid, m_complete, m_rdata,
    output sdram_request, sdram_write, sdram_master, sdram_address,
           sdram_wdata, sdram_byte_en, sdram_burst,
    input  sdram_ready, sdram_rdata, sdram_valid, sdram_complete
  );

  modport master (
    output m_request, m_write, m_burst, m_address, m_wdata, m_byte_en,
    input  m_ack, m_valid, m_complete, m_rdata,
    input  sdram_request, sdram_write, sdram_master, sdram_address,
           sdram_wdata, sdram_byte_en, sdram_burst,
    output sdram_ready, sdram_rdata, sdram_valid, sdram_complete
  );
endinterface

// File: rtl/sdram_arbiter_nport.sv
// N-master SDRAM arbiter: fixed-priority or round-robin grant with age promotion,
// one registered command stage towards the controller, tag-decoded read return.
module sdram_arbiter_nport #(
  parameter int NUM_MASTERS = 5,
  parameter int ADDR_W      = 26,
  parameter int DATA_W      = 32,
  parameter int ID_W        = 4,
  parameter int RR_MODE     = 0,
  parameter int AGE_LIMIT   = 8
) (
  input logic                 clock,
  input logic                 reset,
  sdram_arbiter_nport_if.slave bus
);
  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int AGE_W = (AGE_LIMIT > 1) ? $clog2(AGE_LIMIT + 1) : 1;
  localparam int BE_W  = DATA_W / 8;
  localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(AGE_LIMIT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);

  logic                   r_request;
  logic                   r_write;
  logic                   r_burst;
  logic [ID_W-1:0]        r_master;
  logic [ADDR_W-1:0]      r_address;
  logic [DATA_W-1:0]      r_wdata;
  logic [BE_W-1:0]        r_byte_en;
  logic [IDX_W-1:0]       r_last_grant;

  logic [NUM_MASTERS-1:0] w_aged;
  logic [NUM_MASTERS-1:0] w_upper;
  logic [NUM_MASTERS-1:0] w_aged_req;
  logic [NUM_MASTERS-1:0] w_upper_req;
  logic [NUM_MASTERS-1:0] w_ack;
  logic [IDX_W-1:0]       w_sel;
  logic                   w_any_req;
  logic                   w_grant;

  function automatic logic [IDX_W-1:0] f_lowest(input logic [NUM_MASTERS-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  assign w_any_req   = |bus.m_request;
  assign w_aged_req  = bus.m_request & w_aged;
  assign w_upper_req = bus.m_request & w_upper;
  // No grant while reset is held: the command register clears on that edge,
  // so an accepted request would be silently lost.
  assign w_grant     = bus.sdram_ready & w_any_req & ~reset;

  always_comb begin
    w_sel = f_lowest(bus.m_request);
    if ((AGE_LIMIT != 0) && (|w_aged_req)) begin
      w_sel = f_lowest(w_aged_req);
    end else if ((RR_MODE != 0) && (|w_upper_req)) begin
      w_sel = f_lowest(w_upper_req);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_port
      logic [AGE_W-1:0] r_age;

      // Clearing on "not requesting" also covers the acked-then-dropped cycle.
      always_ff @(posedge clock) begin
        if (reset) begin
          r_age <= '0;
        end else if (bus.sdram_ready) begin
          if (!bus.m_request[gi] || w_ack[gi]) begin
            r_age <= '0;
          end else if (w_grant && (r_age < AGE_MAX)) begin
            r_age <= r_age + AGE_W'(1);
          end
        end
      end

      assign w_aged[gi]         = (AGE_LIMIT != 0) && (r_age >= AGE_MAX);
      assign w_upper[gi]        = (IDX_W'(gi) > r_last_grant);
      assign w_ack[gi]          = w_grant && (w_sel == IDX_W'(gi));
      assign bus.m_valid[gi]    = (bus.sdram_valid == ID_W'(gi + 1));
      assign bus.m_complete[gi] = (bus.sdram_complete == ID_W'(gi + 1));
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      r_request    <= 1'b0;
      r_write      <= 1'b0;
      r_burst      <= 1'b0;
      r_master     <= '0;
      r_address    <= '0;
      r_wdata      <= '0;
      r_byte_en    <= '0;
      r_last_grant <= LAST_IDX;
    end else if (bus.sdram_ready) begin
      r_request <= w_any_req;
      if (w_any_req) begin
        r_master     <= ID_W'(w_sel) + ID_W'(1);
        r_write      <= bus.m_write[w_sel];
        r_burst      <= bus.m_burst[w_sel];
        r_address    <= bus.m_address[w_sel*ADDR_W +: ADDR_W];
        r_wdata      <= bus.m_wdata[w_sel*DATA_W +: DATA_W];
        r_byte_en    <= bus.m_byte_en[w_sel*BE_W +: BE_W];
        r_last_grant <= w_sel;
      end else begin
        r_master <= '0;
      end
    end
  end

  assign bus.m_ack         = w_ack;
  assign bus.m_rdata       = (bus.sdram_valid != '0) ? bus.sdram_rdata : '0;
  assign bus.sdram_request = r_request;
  assign bus.sdram_write   = r_write;
  assign bus.sdram_burst   = r_burst;
  assign bus.sdram_master  = r_master;
  assign bus.sdram_address = r_address;
  assign bus.sdram_wdata   = r_wdata;
  assign bus.sdram_byte_en = r_byte_en;
endmodule

// File: tb/tb_sdram_arbiter_nport.sv
// Directed bench: three arbiter instances (fixed, round-robin, ageing) on one clock,
// hand-computed expectations for handshake, hold, arbitration order and read return.
module tb_sdram_arbiter_nport;
  localparam int NM = 5;
  localparam int AW = 26;
  localparam int DW = 32;
  localparam int IW = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sdram_arbiter_nport_if #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) bus_fp ();
  sdram_arbiter_nport_if #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) bus_rr ();
  sdram_arbiter_nport_if #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) bus_ag ();

  sdram_arbiter_nport #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW),
                        .RR_MODE(0), .AGE_LIMIT(8))
    dut_fp (.clock(clock), .reset(reset), .bus(bus_fp));
  sdram_arbiter_nport #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW),
                        .RR_MODE(1), .AGE_LIMIT(8))
    dut_rr (.clock(clock), .reset(reset), .bus(bus_rr));
  sdram_arbiter_nport #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW),
                        .RR_MODE(0), .AGE_LIMIT(3))
    dut_ag (.clock(clock), .reset(reset), .bus(bus_ag));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  int rr_exp[6] = '{0, 1, 4, 0, 1, 4};
  int ag_exp[8] = '{0, 0, 0, 3, 0, 0, 0, 3};

  initial begin
    bus_fp.m_request = '0; bus_fp.m_write = '0; bus_fp.m_burst = '0;
    bus_fp.m_address = '0; bus_fp.m_wdata = '0; bus_fp.m_byte_en = '0;
    bus_fp.sdram_ready = 1'b1; bus_fp.sdram_rdata = '0;
    bus_fp.sdram_valid = '0; bus_fp.sdram_complete = '0;
    bus_rr.m_request = '0; bus_rr.m_write = '0; bus_rr.m_burst = '0;
    bus_rr.m_address = '0; bus_rr.m_wdata = '0; bus_rr.m_byte_en = '0;
    bus_rr.sdram_ready = 1'b1; bus_rr.sdram_rdata = '0;
    bus_rr.sdram_valid = '0; bus_rr.sdram_complete = '0;
    bus_ag.m_request = '0; bus_ag.m_write = '0; bus_ag.m_burst = '0;
    bus_ag.m_address = '0; bus_ag.m_wdata = '0; bus_ag.m_byte_en = '0;
    bus_ag.sdram_ready = 1'b1; bus_ag.sdram_rdata = '0;
    bus_ag.sdram_valid = '0; bus_ag.sdram_complete = '0;

    step(); step();
    reset = 1'b0;
    #1;
    check("rst_request", bus_fp.sdram_request, 0);
    check("rst_master",  bus_fp.sdram_master, 0);
    check("rst_address", bus_fp.sdram_address, 0);
    check("rst_wdata",   bus_fp.sdram_wdata, 0);
    check("rst_ack",     bus_fp.m_ack, 0);

    // Master 2 read, acked in the same cycle it is raised.
    bus_fp.m_request = 5'b00100;
    bus_fp.m_address[2*AW +: AW] = 26'h0001234;
    #1;
    check("rd_ack", bus_fp.m_ack, 5'b00100);
    step();
    // Master 2 drops; master 1 raises a write while the slave stalls.
    bus_fp.m_request = 5'b00010;
    bus_fp.m_write[1] = 1'b1;
    bus_fp.m_burst[1] = 1'b1;
    bus_fp.m_address[1*AW +: AW] = 26'h0000ABC;
    bus_fp.m_wdata[1*DW +: DW] = 32'hA5A5_5A5A;
    bus_fp.m_byte_en[1*4 +: 4] = 4'b0011;
    bus_fp.sdram_ready = 1'b0;
    #1;
    check("rd_request", bus_fp.sdram_request, 1);
    check("rd_master",  bus_fp.sdram_master, 3);
    check("rd_address", bus_fp.sdram_address, 26'h0001234);
    check("rd_write",   bus_fp.sdram_write, 0);
    check("stall_ack0", bus_fp.m_ack, 0);
    for (int c = 0; c < 4; c++) begin
      step();
      check("stall_ack",     bus_fp.m_ack, 0);
      check("stall_request", bus_fp.sdram_request, 1);
      check("stall_master",  bus_fp.sdram_master, 3);
      check("stall_address", bus_fp.sdram_address, 26'h0001234);
    end
    bus_fp.sdram_ready = 1'b1;
    #1;
    check("wr_ack", bus_fp.m_ack, 5'b00010);
    step();
    bus_fp.m_request = '0;
    #1;
    check("wr_request", bus_fp.sdram_request, 1);
    check("wr_master",  bus_fp.sdram_master, 2);
    check("wr_address", bus_fp.sdram_address, 26'h0000ABC);
    check("wr_write",   bus_fp.sdram_write, 1);
    check("wr_wdata",   bus_fp.sdram_wdata, 32'hA5A5_5A5A);
    check("wr_byte_en", bus_fp.sdram_byte_en, 4'b0011);
    check("wr_burst",   bus_fp.sdram_burst, 1);
    step();
    check("idle_request", bus_fp.sdram_request, 0);
    check("idle_master",  bus_fp.sdram_master, 0);
    check("idle_address", bus_fp.sdram_address, 26'h0000ABC);

    // Read return decode.
    bus_fp.sdram_rdata = 32'hDEADBEEF;
    bus_fp.sdram_valid = 4'd2;
    #1;
    check("ret2_valid", bus_fp.m_valid, 5'b00010);
    check("ret2_rdata", bus_fp.m_rdata, 32'hDEADBEEF);
    bus_fp.sdram_valid = 4'd7;
    #1;
    check("ret7_valid", bus_fp.m_valid, 0);
    check("ret7_rdata", bus_fp.m_rdata, 32'hDEADBEEF);
    bus_fp.sdram_valid = 4'd0;
    #1;
    check("ret0_valid", bus_fp.m_valid, 0);
    check("ret0_rdata", bus_fp.m_rdata, 0);
    bus_fp.sdram_complete = 4'd5;
    #1;
    check("cmp5", bus_fp.m_complete, 5'b10000);
    bus_fp.sdram_complete = 4'd6;
    #1;
    check("cmp6", bus_fp.m_complete, 0);
    bus_fp.sdram_complete = 4'd0;

    // Ack and returning data for the same master together.
    bus_fp.m_request = 5'b00001;
    bus_fp.sdram_valid = 4'd1;
    #1;
    check("both_ack",   bus_fp.m_ack, 5'b00001);
    check("both_valid", bus_fp.m_valid, 5'b00001);
    step();
    bus_fp.m_request = '0;
    bus_fp.sdram_valid = '0;

    // Reset while a command is pending and master 4 keeps requesting.
    bus_fp.m_request = 5'b10000;
    bus_fp.m_address[4*AW +: AW] = 26'h3FF_FFFF;
    #1;
    check("m4_ack", bus_fp.m_ack, 5'b10000);
    step();
    check("m4_request", bus_fp.sdram_request, 1);
    check("m4_master",  bus_fp.sdram_master, 5);
    reset = 1'b1;
    #1;
    check("rst_mid_ack", bus_fp.m_ack, 0);
    step();
    check("rst_mid_request", bus_fp.sdram_request, 0);
    check("rst_mid_master",  bus_fp.sdram_master, 0);
    check("rst_mid_address", bus_fp.sdram_address, 0);
    bus_fp.m_request = '0;
    reset = 1'b0;
    step();

    // Round-robin among masters 0, 1, 4.
    bus_rr.m_request = 5'b10011;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("rr_ack%0d", i), bus_rr.m_ack, 5'(1) << rr_exp[i]);
      step();
      check($sformatf("rr_master%0d", i), bus_rr.sdram_master, rr_exp[i] + 1);
    end
    bus_rr.m_request = '0;

    // Fixed priority with age promotion at 3 lost arbitrations.
    bus_ag.m_request = 5'b01001;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("age_ack%0d", i), bus_ag.m_ack, 5'(1) << ag_exp[i]);
      step();
      check($sformatf("age_master%0d", i), bus_ag.sdram_master, ag_exp[i] + 1);
    end
    bus_ag.m_request = '0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sdram_arbiter_nport.md
Name: sdram_arbiter_nport

Overview:
Parametrised N-master SDRAM arbiter with selectable fixed-priority or round-robin grant. It adds an anti-starvation age promotion that lifts any master kept waiting too long. It sits between the bus masters (dcache, icache, VGA, blitter read/write, future DMA) and the single SDRAM controller slave, and routes tagged read data back to the issuing master.

Parameters:
NUM_MASTERS, 5, number of master ports; master i carries ID i+1, and ID 0 means idle.
ADDR_W, 26, address width.
DATA_W, 32, data width; must be a multiple of 8.
ID_W, 4, master-ID tag width; requires NUM_MASTERS <= 2^ID_W - 1.
RR_MODE, 0, 0 = fixed priority (lowest index wins); 1 = round-robin.
AGE_LIMIT, 8, lost arbitrations before a waiting master is promoted; 0 disables ageing.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
m_request  in  NUM_MASTERS  per-master request
m_write  in  NUM_MASTERS  per-master write flag
m_burst  in  NUM_MASTERS  per-master burst flag
m_address  in  NUM_MASTERS*ADDR_W  packed; master i occupies [i*ADDR_W +: ADDR_W]
m_wdata  in  NUM_MASTERS*DATA_W  packed write data
m_byte_en  in  NUM_MASTERS*DATA_W/8  packed byte enables
m_ack  out  NUM_MASTERS  one-hot accept pulse
m_valid  out  NUM_MASTERS  read-data-valid, decoded from the tag
m_complete  out  NUM_MASTERS  transaction complete, decoded from the tag
m_rdata  out  DATA_W  shared read data
sdram_request  out  1  registered request to the slave
sdram_write  out  1  registered write flag
sdram_master  out  ID_W  ID of the issued transaction
sdram_address  out  ADDR_W  registered address
sdram_wdata  out  DATA_W  registered write data
sdram_byte_en  out  DATA_W/8  registered byte enables
sdram_burst  out  1  registered burst flag
sdram_ready  in  1  slave can accept a command this cycle
sdram_rdata  in  DATA_W  read data
sdram_valid  in  ID_W  ID of the returning read beat; 0 = none
sdram_complete  in  ID_W  ID of the completed transaction; 0 = none

Behaviour:
- Handshake: a master holds its request and fields stable until m_ack. m_ack may fire in the same cycle the request is raised. The master drops its request the cycle after ack.
- Grant is combinational and evaluated only when sdram_ready=1. m_ack[g] = sdram_ready & request[g] & (g selected). At most one ack bit is high.
- Selection order:
  (a) If any requesting master has age >= AGE_LIMIT (and AGE_LIMIT != 0), grant the lowest-index aged master.
  (b) Otherwise, if RR_MODE=1, grant the first requester scanning from last_grant+1 upward, wrapping modulo NUM_MASTERS.
  (c) Otherwise, grant the lowest-index requester.
- On a clock edge with sdram_ready=1:
  - sdram_request <= any request.
  - sdram_master <= g+1, or 0 if there is no request.
  - Address, write, wdata, byte_en and burst are latched from master g. With no request these fields hold their previous values.
  - last_grant <= g, only when a grant occurs.
- On a clock edge with sdram_ready=0: all sdram_* outputs, last_grant and ages hold. Latency from ack to sdram_request is exactly 1 cycle.
- Age counters: per master, saturating at AGE_LIMIT.
  - Increments when that master requests, a grant goes to another master, and the counter is below the limit.
  - Cleared when that master is acked or is not requesting.
  - Held when no grant occurs.
- Read return: m_valid[i] = (sdram_valid == i+1); m_complete[i] = (sdram_complete == i+1). Tag values above NUM_MASTERS are ignored. m_rdata = sdram_rdata when sdram_valid != 0, else all zeros.
- Reset values: sdram_request=0, sdram_master=0, sdram_write=0, sdram_address=0, sdram_wdata=0, sdram_byte_en=0, sdram_burst=0, last_grant=NUM_MASTERS-1 (so master 0 wins first in RR mode), all ages 0. Combinational outputs follow their inputs.
- Reset asserted mid-transaction: registers clear on that edge. In-flight read tags still decode to m_valid/m_complete; the slave is responsible for flushing them.
- Simultaneous ack and returning data for the same master is legal; both are asserted.

Test Plan:
- Reset, then master 2 requests a read at 0x0001234 with sdram_ready=1 -> m_ack=5'b00100 in the same cycle; next cycle sdram_request=1, sdram_master=3, sdram_address=0x0001234, sdram_write=0.
- RR_MODE=1, masters 0/1/4 requesting continuously, ready=1 -> grant sequence 0,1,4,0,1,4.
- RR_MODE=0, AGE_LIMIT=3, masters 0 and 3 requesting continuously -> grants 0,0,0, then 3 on the fourth grant; master 3's age then clears.
- Master 1 requesting with sdram_ready=0 for 4 cycles -> no ack and sdram_* outputs unchanged; when ready rises, ack is issued in that cycle.
- sdram_valid=2 with sdram_rdata=0xDEADBEEF -> m_valid=5'b00010, m_rdata=0xDEADBEEF; sdram_valid=7 -> m_valid=0 and m_rdata=0xDEADBEEF; sdram_valid=0 -> m_rdata=0.
- Reset asserted while sdram_request=1 and master 4 is requesting -> next edge sdram_request=0, sdram_master=0, no m_ack during reset.
